sentinel_key_conditioner: RTL and testbench

Input conditioning stage directly upstream of the Sentinel lock comparator. It synchronises the raw 8-bit DIP-switch key from `ui_in` into the clock domain and debounces it. It presents a key only after the key has been stable for a programmable number of cycles. After every key change it can enforce a cooldown window that throttles brute-force attempts. The downstream comparator evaluates `key_out` only while `key_valid` is high.

---
 rtl/sentinel_key_conditioner_if.sv | 36 +++
 rtl/sentinel_key_conditioner.sv | 153 +++++++++++++++
 tb/tb_sentinel_key_conditioner.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sentinel_key_conditioner_if.sv
// Sentinel key conditioner bus: groups the enable, raw key input and
// conditioned key outputs into one bundle.
//   ena        power-state enable (low = synchronous flush)
//   key_raw    asynchronous 8-bit DIP-switch key
//   key_out    last committed key
//   key_valid  key_out matches the current synchronised input
//   key_strobe one-cycle pulse on every commit
//   busy       cooldown window active
// master: the side driving the raw key (board / testbench).
// slave:  the conditioner itself.
interface sentinel_key_conditioner_if;
    logic       ena;
    logic [7:0] key_raw;
    logic [7:0] key_out;
    logic       key_valid;
    logic       key_strobe;
    logic       busy;

    modport master (
        output ena,
        output key_raw,
        input  key_out,
        input  key_valid,
        input  key_strobe,
        input  busy
    );

    modport slave (
        input  ena,
        input  key_raw,
        output key_out,
        output key_valid,
        output key_strobe,
        output busy
    );
endinterface

// File: rtl/sentinel_key_conditioner.sv
// Sentinel key conditioner: synchronises and debounces the raw DIP-switch key
// ahead of the lock comparator. A key is committed to key_out only after it has
// been stable for STABLE_CYCLES consecutive cycles. With SENTINEL_COOLDOWN_EN
// defined, disturbing a committed key opens a COOLDOWN_CYCLES lockout window
// (busy high) before settling may start again.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   kc     sentinel_key_conditioner_if.slave (ena, key_raw, key_out,
//          key_valid, key_strobe, busy)
// Optional feature macro: SENTINEL_COOLDOWN_EN
module sentinel_key_conditioner #(
    parameter int unsigned STABLE_CYCLES   = 16,
    parameter int unsigned COOLDOWN_CYCLES = 64
) (
    input logic                      clk,
    input logic                      rst_n,
    sentinel_key_conditioner_if.slave kc
);

    localparam int unsigned CntW = $clog2(STABLE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 1024) begin : g_bad_stable
        $error("STABLE_CYCLES out of range 2..1024");
    end
    if (COOLDOWN_CYCLES < 1 || COOLDOWN_CYCLES > 65535) begin : g_bad_cooldown
        $error("COOLDOWN_CYCLES out of range 1..65535");
    end

`ifdef SENTINEL_COOLDOWN_EN
    localparam int unsigned CcntW = $clog2(COOLDOWN_CYCLES + 1);
    localparam logic [CcntW-1:0] CcntLoad = CcntW'(COOLDOWN_CYCLES - 1);

    typedef enum logic [1:0] {StSettle, StStable, StCooldown} state_e;

    logic [CcntW-1:0] ccnt_q, ccnt_d;
`else
    typedef enum logic [1:0] {StSettle, StStable} state_e;
`endif

    state_e          state_q, state_d;
    logic [7:0]      sync1_q, sync2_q;
    logic [7:0]      cand_q, cand_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      key_out_q, key_out_d;
    logic            valid_q, valid_d;
    logic            strobe_q, strobe_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StSettle;
            sync1_q   <= '0;
            sync2_q   <= '0;
            cand_q    <= '0;
            cnt_q     <= '0;
            key_out_q <= '0;
            valid_q   <= 1'b0;
            strobe_q  <= 1'b0;
`ifdef SENTINEL_COOLDOWN_EN
            ccnt_q    <= '0;
`endif
        end else begin
            // Synchroniser runs regardless of ena.
            sync1_q   <= kc.key_raw;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            key_out_q <= key_out_d;
            valid_q   <= valid_d;
            strobe_q  <= strobe_d;
`ifdef SENTINEL_COOLDOWN_EN
            ccnt_q    <= ccnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        key_out_d = key_out_q;
        valid_d   = valid_q;
        strobe_d  = 1'b0;
`ifdef SENTINEL_COOLDOWN_EN
        ccnt_d    = ccnt_q;
`endif
        if (!kc.ena) begin
            // Flush beats every transition; key_out deliberately holds.
            state_d = StSettle;
            cnt_d   = '0;
            valid_d = 1'b0;
            cand_d  = sync2_q;
`ifdef SENTINEL_COOLDOWN_EN
            ccnt_d  = '0;
`endif
        end else begin
            unique case (state_q)
                StSettle: begin
                    if (sync2_q != cand_q) begin
                        cand_d = sync2_q;
                        cnt_d  = '0;
                    end else if (cnt_q == CntLast) begin
                        // Commits even if cand equals the old key_out.
                        key_out_d = cand_q;
                        valid_d   = 1'b1;
                        strobe_d  = 1'b1;
                        state_d   = StStable;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StStable: begin
                    if (sync2_q != key_out_q) begin
                        valid_d = 1'b0;
                        cand_d  = sync2_q;
`ifdef SENTINEL_COOLDOWN_EN
                        state_d = StCooldown;
                        ccnt_d  = CcntLoad;
`else
                        state_d = StSettle;
                        cnt_d   = '0;
`endif
                    end
                end
`ifdef SENTINEL_COOLDOWN_EN
                StCooldown: begin
                    // Changes here only update cand; the window is not extended.
                    cand_d = sync2_q;
                    if (ccnt_q == '0) begin
                        state_d = StSettle;
                        cnt_d   = '0;
                    end else begin
                        ccnt_d = ccnt_q - 1'b1;
                    end
                end
`endif
                default: state_d = StSettle;
            endcase
        end
    end

    assign kc.key_out    = key_out_q;
    assign kc.key_valid  = valid_q;
    assign kc.key_strobe = strobe_q;
`ifdef SENTINEL_COOLDOWN_EN
    assign kc.busy       = (state_q == StCooldown);
`else
    assign kc.busy       = 1'b0;
`endif

endmodule

// File: tb/tb_sentinel_key_conditioner.sv
module tb_sentinel_key_conditioner;

    localparam int StableCycles   = 16;
    localparam int CooldownCycles = 64;
`ifdef SENTINEL_COOLDOWN_EN
    localparam bit CdEn = 1'b1;
`else
    localparam bit CdEn = 1'b0;
`endif
    // Edges from a key_raw change to the commit.
    localparam int CommitLat = CdEn ? (3 + CooldownCycles + StableCycles) : (3 + StableCycles);

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;

    typedef struct {
        logic [7:0] key;
        int         at_cyc;
    } exp_t;
    exp_t sb[$];

    sentinel_key_conditioner_if kc_if ();

    sentinel_key_conditioner #(
        .STABLE_CYCLES  (StableCycles),
        .COOLDOWN_CYCLES(CooldownCycles)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .kc   (kc_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Pure wait: returns at the negedge where a strobe is seen, or after budget.
    task automatic wait_strobe(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (kc_if.key_strobe === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit   got;
        int   t0;
        exp_t e;
        kc_if.ena     = 1'b1;
        kc_if.key_raw = 8'h00;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (kc_if.key_out !== 8'h00) begin
            failures++; $display("FAIL reset_key_out got=%h want=00", kc_if.key_out);
        end
        checks++;
        if (kc_if.key_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%b want=0", kc_if.key_valid);
        end
        checks++;
        if (kc_if.key_strobe !== 1'b0) begin
            failures++; $display("FAIL reset_strobe got=%b want=0", kc_if.key_strobe);
        end
        checks++;
        if (kc_if.busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy got=%b want=0", kc_if.busy);
        end
        rst_n = 1'b1;
        t0    = cyc;
        sb.push_back('{key: 8'h00, at_cyc: t0 + StableCycles});
        wait_strobe(StableCycles + 10, got);
        checks++;
        if (!got) begin
            failures++; $display("FAIL reset_commit_timeout got=none want=strobe");
        end else if (sb.size() == 0) begin
            failures++; $display("FAIL reset_sb_empty got=strobe want=none");
        end else begin
            e = sb.pop_front();
            if (kc_if.key_out !== e.key || cyc != e.at_cyc || kc_if.key_valid !== 1'b1) begin
                failures++;
                $display("FAIL reset_commit got=key %h edge %0d valid %b want=key %h edge %0d valid 1",
                         kc_if.key_out, cyc - t0, kc_if.key_valid, e.key, e.at_cyc - t0);
            end
        end
        @(negedge clk);
        checks++;
        if (kc_if.key_strobe !== 1'b0) begin
            failures++; $display("FAIL reset_strobe_width got=%b want=0", kc_if.key_strobe);
        end
    endtask

    // Change from a stable key to new_key and track busy/valid/strobe each edge.
    task automatic test_change(input logic [7:0] new_key);
        int   t0;
        bit   seen;
        exp_t e;
        logic exp_busy, exp_valid, exp_strobe;
        t0 = cyc;
        kc_if.key_raw = new_key;
        sb.push_back('{key: new_key, at_cyc: t0 + CommitLat});
        seen = 1'b0;
        for (int n = 1; n <= CommitLat + 1; n++) begin
            @(negedge clk);
            exp_busy   = CdEn && (n >= 3) && (n <= 2 + CooldownCycles);
            exp_valid  = (n <= 2) || (n >= CommitLat);
            exp_strobe = (n == CommitLat);
            checks++;
            if (kc_if.busy !== exp_busy || kc_if.key_valid !== exp_valid ||
                kc_if.key_strobe !== exp_strobe) begin
                failures++;
                $display("FAIL change_edge%0d got=busy %b valid %b strobe %b want=busy %b valid %b strobe %b",
                         n, kc_if.busy, kc_if.key_valid, kc_if.key_strobe,
                         exp_busy, exp_valid, exp_strobe);
            end
            if (kc_if.key_strobe === 1'b1 && !seen) begin
                seen = 1'b1;
                checks++;
                if (sb.size() == 0) begin
                    failures++; $display("FAIL change_sb_empty got=strobe want=none");
                end else begin
                    e = sb.pop_front();
                    if (kc_if.key_out !== e.key || cyc != e.at_cyc) begin
                        failures++;
                        $display("FAIL change_commit got=key %h edge %0d want=key %h edge %0d",
                                 kc_if.key_out, cyc - t0, e.key, e.at_cyc - t0);
                    end
                end
            end
        end
        checks++;
        if (!seen) begin
            failures++; $display("FAIL change_no_commit got=none want=strobe");
            sb.delete();
        end
    endtask

    // Toggle bit 7 every 5 cycles for 40 cycles; ends on 0xB6.
    task automatic test_bounce();
        int   t0;
        int   last;
        bit   got;
        exp_t e;
        t0   = cyc;
        last = 0;
        for (int i = 0; i < 40; i++) begin
            if (i % 5 == 0) begin
                kc_if.key_raw = kc_if.key_raw ^ 8'h80;
                last = i;
            end
            @(negedge clk);
            checks++;
            if (kc_if.key_strobe !== 1'b0) begin
                failures++; $display("FAIL bounce_strobe_i%0d got=1 want=0", i);
            end
        end
        checks++;
        if (kc_if.key_raw !== 8'hB6) begin
            failures++; $display("FAIL bounce_final_raw got=%h want=b6", kc_if.key_raw);
        end
        sb.push_back('{key: 8'hB6,
                       at_cyc: CdEn ? (t0 + CommitLat) : (t0 + last + 3 + StableCycles)});
        wait_strobe(200, got);
        checks++;
        if (!got) begin
            failures++; $display("FAIL bounce_commit_timeout got=none want=strobe");
            sb.delete();
        end else if (sb.size() == 0) begin
            failures++; $display("FAIL bounce_sb_empty got=strobe want=none");
        end else begin
            e = sb.pop_front();
            if (kc_if.key_out !== e.key || cyc != e.at_cyc || kc_if.busy !== 1'b0) begin
                failures++;
                $display("FAIL bounce_commit got=key %h edge %0d busy %b want=key %h edge %0d busy 0",
                         kc_if.key_out, cyc - t0, kc_if.busy, e.key, e.at_cyc - t0);
            end
        end
    endtask

    task automatic test_ena_drop();
        int   t0;
        bit   got;
        exp_t e;
        kc_if.ena = 1'b0;
        @(negedge clk);
        kc_if.ena = 1'b1;
        t0 = cyc;
        checks++;
        if (kc_if.key_valid !== 1'b0 || kc_if.key_out !== 8'hB6 || kc_if.key_strobe !== 1'b0) begin
            failures++;
            $display("FAIL ena_flush got=valid %b key %h strobe %b want=valid 0 key b6 strobe 0",
                     kc_if.key_valid, kc_if.key_out, kc_if.key_strobe);
        end
        sb.push_back('{key: 8'hB6, at_cyc: t0 + StableCycles});
        wait_strobe(StableCycles + 10, got);
        checks++;
        if (!got) begin
            failures++; $display("FAIL ena_commit_timeout got=none want=strobe");
            sb.delete();
        end else if (sb.size() == 0) begin
            failures++; $display("FAIL ena_sb_empty got=strobe want=none");
        end else begin
            e = sb.pop_front();
            if (kc_if.key_out !== e.key || cyc != e.at_cyc || kc_if.key_valid !== 1'b1) begin
                failures++;
                $display("FAIL ena_recommit got=key %h edge %0d valid %b want=key %h edge %0d valid 1",
                         kc_if.key_out, cyc - t0, kc_if.key_valid, e.key, e.at_cyc - t0);
            end
        end
    endtask

    task automatic test_reset_mid_cooldown();
        kc_if.key_raw = 8'h00;
        repeat (10) @(negedge clk);
        checks++;
        if (kc_if.busy !== CdEn || kc_if.key_valid !== 1'b0) begin
            failures++;
            $display("FAIL midcd_state got=busy %b valid %b want=busy %b valid 0",
                     kc_if.busy, kc_if.key_valid, CdEn);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (kc_if.key_out !== 8'h00 || kc_if.key_valid !== 1'b0 ||
            kc_if.key_strobe !== 1'b0 || kc_if.busy !== 1'b0) begin
            failures++;
            $display("FAIL midcd_async_reset got=key %h valid %b strobe %b busy %b want=00 0 0 0",
                     kc_if.key_out, kc_if.key_valid, kc_if.key_strobe, kc_if.busy);
        end
        // Re-release behaves like the first bring-up.
        test_reset();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        kc_if.ena     = 1'b1;
        kc_if.key_raw = 8'h00;
        @(negedge clk);
        test_reset();
        test_change(8'hB6);
        test_bounce();
        test_ena_drop();
        test_reset_mid_cooldown();
        checks++;
        if (sb.size() != 0) begin
            failures++; $display("FAIL sb_leftover got=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
